// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types, BCD limits and digit packing for the countdown timer
package timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} timer_state_t;

  localparam logic [3:0] BCD_ONES_MAX = 4'd9;
  localparam logic [3:0] BCD_TENS_MAX = 4'd5;

  localparam int SEC_ONES_LSB = 0;
  localparam int SEC_TENS_LSB = 4;
  localparam int MIN_ONES_LSB = 8;
  localparam int MIN_TENS_LSB = 12;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max_v);
    return (d > max_v) ? max_v : d;
  endfunction

  function automatic logic [15:0] sanitize_preset(input logic [15:0] p);
    logic [15:0] r;
    r[SEC_ONES_LSB +: 4] = clamp_digit(p[SEC_ONES_LSB +: 4], BCD_ONES_MAX);
    r[SEC_TENS_LSB +: 4] = clamp_digit(p[SEC_TENS_LSB +: 4], BCD_TENS_MAX);
    r[MIN_ONES_LSB +: 4] = clamp_digit(p[MIN_ONES_LSB +: 4], BCD_ONES_MAX);
    r[MIN_TENS_LSB +: 4] = clamp_digit(p[MIN_TENS_LSB +: 4], BCD_TENS_MAX);
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// rtl/bcd_digit_dec.sv - one BCD digit of a borrow-chained decrementer
module bcd_digit_dec (
  input  logic [3:0] digit_i,
  input  logic [3:0] max_i,
  input  logic       borrow_i,
  output logic [3:0] digit_o,
  output logic       borrow_o
);

  always_comb begin
    digit_o  = digit_i;
    borrow_o = 1'b0;
    if (borrow_i) begin
      if (digit_i == 4'd0) begin
        digit_o  = max_i;
        borrow_o = 1'b1;
      end else begin
        digit_o = digit_i - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - mm:ss BCD countdown with start/pause/load control
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int TICKS_PER_STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_src,
  input  logic        load,
  input  logic [15:0] preset,
  input  logic        start_pause,
  output logic [15:0] digits,
  output logic        running,
  output logic        done
);

  localparam logic [7:0] LAST_STEP = 8'(TICKS_PER_STEP - 1);

  timer_state_t state_q;
  logic [15:0]  digits_q;
  logic [7:0]   step_cnt_q;
  logic         tick_q;
  logic         running_q;
  logic         done_q;

  logic         tick_edge;
  logic [15:0]  dec_raw;
  logic [15:0]  dec_value;
  logic         dec_zero;
  logic [4:0]   borrow;

  assign tick_edge = tick_src & ~tick_q;
  assign borrow[0] = 1'b1;

  // Even fields are ones digits (wrap to 9), odd fields are tens digits (wrap to 5).
  for (genvar g = 0; g < 4; g++) begin : g_dec
    bcd_digit_dec u_dec (
      .digit_i  (digits_q[4*g +: 4]),
      .max_i    ((g % 2 == 0) ? BCD_ONES_MAX : BCD_TENS_MAX),
      .borrow_i (borrow[g]),
      .digit_o  (dec_raw[4*g +: 4]),
      .borrow_o (borrow[g+1])
    );
  end

  // A borrow out of the top digit would mean wrapping below 00:00; pin it at zero instead.
  assign dec_value = borrow[4] ? 16'h0000 : dec_raw;
  assign dec_zero  = (dec_value == 16'h0000);

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q     <= 1'b0;
      state_q    <= IDLE;
      digits_q   <= 16'h0000;
      step_cnt_q <= 8'd0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      tick_q <= tick_src;
      if (load) begin
        digits_q   <= sanitize_preset(preset);
        step_cnt_q <= 8'd0;
        state_q    <= IDLE;
        running_q  <= 1'b0;
        done_q     <= 1'b0;
      end else if (start_pause) begin
        case (state_q)
          IDLE: begin
            if (digits_q != 16'h0000) begin
              state_q   <= RUN;
              running_q <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
          RUN: begin
            state_q   <= PAUSE;
            running_q <= 1'b0;
          end
          PAUSE: begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
          DONE: ;
        endcase
      end else if (state_q == RUN && tick_edge) begin
        if (step_cnt_q == LAST_STEP) begin
          step_cnt_q <= 8'd0;
          digits_q   <= dec_value;
          if (dec_zero) begin
            state_q   <= DONE;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end
        end else begin
          step_cnt_q <= step_cnt_q + 8'd1;
        end
      end
    end
  end

  assign digits  = digits_q;
  assign running = running_q;
  assign done    = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb/tb_bcd_countdown_timer.sv - randomized and directed checks of two timer instances against a seconds-based model
module tb_bcd_countdown_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_src = 1'b0;
  logic        load = 1'b0;
  logic [15:0] preset = 16'h0000;
  logic        start_pause = 1'b0;

  logic [15:0] dig [2];
  logic        run_o [2];
  logic        done_o [2];

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  bcd_countdown_timer #(.TICKS_PER_STEP(1)) u_dut1 (
    .clk(clk), .rst(rst), .tick_src(tick_src), .load(load), .preset(preset),
    .start_pause(start_pause), .digits(dig[0]), .running(run_o[0]), .done(done_o[0])
  );

  bcd_countdown_timer #(.TICKS_PER_STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .tick_src(tick_src), .load(load), .preset(preset),
    .start_pause(start_pause), .digits(dig[1]), .running(run_o[1]), .done(done_o[1])
  );

  // Model: remaining time in plain seconds; mode 0=idle 1=run 2=pause 3=done.
  int m_secs [2];
  int m_mode [2];
  int m_cnt  [2];
  int tps    [2];
  bit m_prev;

  initial begin
    tps[0] = 1; tps[1] = 4;
    for (int k = 0; k < 2; k++) begin
      m_secs[k] = 0; m_mode[k] = 0; m_cnt[k] = 0;
    end
    m_prev = 1'b0;
  end

  function automatic int clampi(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic int preset_secs(input logic [15:0] p);
    int mt, mo, st, so;
    mt = clampi(int'(p[15:12]), 5);
    mo = clampi(int'(p[11:8]), 9);
    st = clampi(int'(p[7:4]), 5);
    so = clampi(int'(p[3:0]), 9);
    return (mt * 10 + mo) * 60 + st * 10 + so;
  endfunction

  function automatic logic [15:0] to_bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int s, m, c;
      bit edge_seen;
      s = m_secs[k]; m = m_mode[k]; c = m_cnt[k];
      edge_seen = tick_src && !m_prev;
      if (rst) begin
        s = 0; m = 0; c = 0;
      end else if (load) begin
        s = preset_secs(preset); m = 0; c = 0;
      end else if (start_pause) begin
        if (m == 0) m = (s != 0) ? 1 : 3;
        else if (m == 1) m = 2;
        else if (m == 2) m = 1;
      end else if (m == 1 && edge_seen) begin
        if (c + 1 == tps[k]) begin
          c = 0;
          s = s - 1;
          if (s == 0) m = 3;
        end else begin
          c = c + 1;
        end
      end
      m_secs[k] <= s;
      m_mode[k] <= m;
      m_cnt[k]  <= c;
    end
    m_prev <= rst ? 1'b0 : tick_src;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dig[k] !== to_bcd(m_secs[k])) begin
          errors++;
          $display("FAIL model_digits dut%0d t=%0t: got %h expected %h", k, $time, dig[k], to_bcd(m_secs[k]));
        end
        checks++;
        if (run_o[k] !== (m_mode[k] == 1)) begin
          errors++;
          $display("FAIL model_running dut%0d t=%0t: got %b expected %b", k, $time, run_o[k], (m_mode[k] == 1));
        end
        checks++;
        if (done_o[k] !== (m_mode[k] == 3)) begin
          errors++;
          $display("FAIL model_done dut%0d t=%0t: got %b expected %b", k, $time, done_o[k], (m_mode[k] == 3));
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic t, input logic l, input logic [15:0] p, input logic sp);
    tick_src = t; load = l; preset = p; start_pause = sp;
    @(posedge clk);
    #1;
  endtask

  task automatic tick_pulse();
    cyc(1'b1, 1'b0, 16'h0, 1'b0);
    cyc(1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    cyc(0, 0, 16'h0, 0);
    cyc(0, 0, 16'h0, 0);
    chk("reset_digits", dig[0], 16'h0000);
    chk("reset_running", {15'd0, run_o[0]}, 16'h0);
    chk("reset_done", {15'd0, done_o[0]}, 16'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    cyc(0, 1, 16'h0003, 0);
    chk("load_0003", dig[0], 16'h0003);
    cyc(0, 0, 16'h0, 1);
    chk("run_after_sp", {15'd0, run_o[0]}, 16'h1);
    cyc(1, 0, 16'h0, 0);
    chk("dec_0002", dig[0], 16'h0002);
    cyc(0, 0, 16'h0, 0);
    cyc(1, 0, 16'h0, 0);
    chk("dec_0001", dig[0], 16'h0001);
    cyc(0, 0, 16'h0, 0);
    cyc(1, 0, 16'h0, 0);
    chk("dec_0000", dig[0], 16'h0000);
    chk("done_at_zero", {15'd0, done_o[0]}, 16'h1);
    chk("running_falls_at_zero", {15'd0, run_o[0]}, 16'h0);
    cyc(0, 0, 16'h0, 0);

    cyc(0, 1, 16'h1000, 0);
    cyc(0, 0, 16'h0, 1);
    tick_pulse();
    chk("borrow_1000_to_0959", dig[0], 16'h0959);
    for (int i = 0; i < 60; i++) tick_pulse();
    chk("sixty_more_0859", dig[0], 16'h0859);

    cyc(0, 1, 16'h0010, 0);
    cyc(0, 0, 16'h0, 1);
    tick_pulse();
    tick_pulse();
    cyc(0, 0, 16'h0, 1);
    chk("tps4_paused", {15'd0, run_o[1]}, 16'h0);
    for (int i = 0; i < 5; i++) tick_pulse();
    chk("tps4_hold_in_pause", dig[1], 16'h0010);
    cyc(0, 0, 16'h0, 1);
    tick_pulse();
    chk("tps4_first_resume_edge", dig[1], 16'h0010);
    tick_pulse();
    chk("tps4_second_resume_edge", dig[1], 16'h0009);

    cyc(0, 1, 16'h7A3F, 0);
    chk("sanitize_7A3F", dig[0], 16'h5939);
    chk("sanitize_idle", {15'd0, run_o[0]}, 16'h0);
    cyc(0, 1, 16'h7A3F, 1);
    chk("load_beats_sp", {15'd0, run_o[0]}, 16'h0);

    cyc(0, 1, 16'h0000, 0);
    cyc(0, 0, 16'h0, 1);
    chk("zero_sp_done", {15'd0, done_o[0]}, 16'h1);
    cyc(0, 0, 16'h0, 1);
    chk("done_ignores_sp", {15'd0, done_o[0]}, 16'h1);
    cyc(0, 1, 16'h0005, 0);
    chk("load_clears_done", {15'd0, done_o[0]}, 16'h0);
    chk("load_0005", dig[0], 16'h0005);

    cyc(0, 0, 16'h0, 1);
    tick_pulse();
    chk("pre_reset_0004", dig[0], 16'h0004);
    rst = 1'b1;
    cyc(1, 0, 16'h0, 0);
    rst = 1'b0;
    chk("rst_digits", dig[0], 16'h0000);
    chk("rst_running", {15'd0, run_o[0]}, 16'h0);
    for (int i = 0; i < 10; i++) cyc(1, 0, 16'h0, 0);
    chk("stuck_high_no_dec", dig[0], 16'h0000);

    for (int i = 0; i < 4000; i++) begin
      logic [15:0] p;
      rst = ($urandom_range(0, 499) == 0);
      p = ($urandom_range(0, 3) == 0) ? 16'($urandom) : {8'h00, 4'($urandom_range(0, 2)), 4'($urandom)};
      cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 149) == 0), p, ($urandom_range(0, 29) == 0));
    end
    rst = 1'b0;
    cyc(0, 0, 16'h0, 0);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

Four-digit BCD mm:ss countdown timer that sits directly downstream of the frequency divider. It consumes the divider's slow output as a level-sampled tick source in the system clock domain and decrements on every qualifying rising edge. A start/pause/load control state machine governs it. Its BCD digits feed the seven-segment scan stage, and `done` drives the alarm/LED logic.

## Interface
- `TICKS_PER_STEP`, default 1: rising edges of `tick_src` per one-second decrement; legal range 1–255.
- `clk`  in  1  system clock; same clock that drives the frequency divider.
- `rst`  in  1  synchronous, active-high reset.
- `tick_src`  in  1  divider output, same clock domain; sampled as a level, never used as a clock.
- `load`  in  1  one-cycle pulse that loads `preset` into the counter.
- `preset`  in  16  BCD {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each.
- `start_pause`  in  1  one-cycle pulse (already debounced/one-pulsed upstream) that toggles run/pause.
- `digits`  out  16  current BCD value, same packing as `preset`.
- `running`  out  1  high in RUN.
- `done`  out  1  high in DONE.

## Operation
- Tick edge: register `tick_q <= tick_src`; `tick_edge = tick_src & ~tick_q`.
- Step counter `step_cnt` (8 bits) counts tick edges in RUN only.
  - When a tick edge arrives with `step_cnt == TICKS_PER_STEP-1`: decrement `digits`, clear `step_cnt`.
  - Otherwise, on a tick edge, increment `step_cnt`.
- States: IDLE, RUN, PAUSE, DONE.
  - IDLE: `start_pause` → RUN if `digits != 0`, else → DONE.
  - RUN: `start_pause` → PAUSE. A decrement that produces 0000 → DONE.
  - PAUSE: `start_pause` → RUN. `step_cnt` is held, not cleared.
  - DONE: `start_pause` is ignored; only `load` leaves DONE.
- `load`, in any state: `digits <= sanitized preset`, `step_cnt <= 0`, state → IDLE.
- Sanitizing: each digit field is clamped. Ones digits above 9 become 9; tens digits above 5 become 5. Example: preset 16'h7A3F loads as 16'h5939.
- BCD decrement with borrow chain:
  - sec_ones 0 → 9 with borrow; sec_tens 0 → 5 with borrow; min_ones 0 → 9 with borrow; min_tens decrements.
  - Example: 10:00 → 09:59.
  - 00:00 is never decremented; DONE is entered instead.
- Priority in one cycle: `rst` > `load` > `start_pause` > tick decrement.
- `start_pause` coinciding with a tick edge: in RUN, the pause wins and the tick is dropped. In IDLE/PAUSE, the tick is ignored and counting begins with the next edge.
- `tick_q` always tracks `tick_src`, in every state, so resume does not create a spurious edge.

## Timing
- Reset values: `digits = 16'h0000`, `running = 0`, `done = 0`, state IDLE, `step_cnt = 0`, `tick_q = 0`.
- All outputs are registered. There is no combinational path from any input to any output.
- Decrement latency: `tick_edge` is seen in cycle N; the new `digits` value is visible from cycle N+1.
- `load` in cycle N: `digits` is valid and `running = 0` from cycle N+1.
- `start_pause` in cycle N: `running` changes at cycle N+1.
- Reaching zero: `digits = 0000` and `done = 1` appear in the same cycle. `running` falls in that cycle too.
- Reset mid-RUN: everything returns to reset values on the next edge. A tick edge in the reset cycle is discarded.
- `tick_src` high for multiple cycles counts as one edge. `tick_src` stuck high produces no further edges.

## Structure
- Shared package `timer_pkg`:
  - state enum `timer_state_t` {IDLE, RUN, PAUSE, DONE};
  - BCD limits `BCD_ONES_MAX = 4'd9` and `BCD_TENS_MAX = 4'd5`;
  - the 16-bit digit packing field offsets.
- One natural sub-module: `bcd_digit_dec`. It takes a digit, a max value, and borrow_in, and returns the next digit and borrow_out. It is instantiated four times as a chain.
- The FSM, tick-edge register and step counter live in the top module.

## Test plan
- Reset, then `load` preset 16'h0003, `start_pause`, and 3 tick edges: `digits` steps 0003 → 0002 → 0001 → 0000, each one cycle after its edge. `done = 1` and `running = 0` with 0000.
- Preset 16'h1000, run, 1 tick: `digits` = 16'h0959. A further 60 ticks give 16'h0859.
- `TICKS_PER_STEP = 4`, preset 16'h0010: pause after 2 edges, apply 5 edges while paused, then resume. The first decrement occurs on the 2nd edge after resume, giving 16'h0009.
- `load` 16'h7A3F: `digits` = 16'h5939 and state is IDLE. Then `start_pause` and `load` in the same cycle: the load wins and `running` stays 0.
- `start_pause` with `digits` = 0000 in IDLE: `done = 1` next cycle. A further `start_pause` leaves `done = 1`; `load` 16'h0005 clears it.
- Assert `rst` mid-RUN, coincident with a tick edge: all outputs are 0 next cycle. Holding `tick_src` high for 10 cycles afterwards yields no decrement.
